// File: rtl/ctrl_link_pkg.sv
// Shared definitions for the serial remote-control link: decoder states,
// frame byte constants, reset values and the unsigned clamp helper.
package ctrl_link_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_B,
        S_CMD,
        S_ST_H,
        S_ST_L,
        S_TH_H,
        S_TH_L,
        S_CSUM,
        S_MODE
    } state_e;

    localparam logic [7:0] HDR_A    = 8'h61;
    localparam logic [7:0] HDR_B    = 8'h62;
    localparam logic [7:0] CMD_CTRL = 8'h63;
    localparam logic [7:0] CMD_MODE = 8'h6D;

    localparam logic [15:0] STEER_RST = 16'd500;
    localparam logic [15:0] THR_RST   = 16'd512;

    function automatic logic [15:0] clamp_u16(input logic [15:0] v, input logic [15:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/ctrl_frame_decoder_byte_timeout.sv
// Inter-byte idle counter: cleared by every byte, held at zero while the
// decoder is idle, expire_c flags the cycle whose edge abandons the frame.
module byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A byte arriving on the expiry cycle wins, so clear masks the expiry.
    assign expire_c = active && !clear && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (clear || !active || expire_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ctrl_frame_decoder.sv
// Remote-control frame decoder: "a b c" control and "a b m" mode frames into
// clamped registered commands. Define CTRL_FRAME_CHECKSUM_EN for an XOR checksum byte.
module ctrl_frame_decoder
    import ctrl_link_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned STEER_MAX      = 1000,
    parameter int unsigned THR_MAX        = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] steer,
    output logic [15:0] throttle,
    output logic        cmd_valid,
    output logic        ctrl_mode,
    output logic        mode_valid,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    if (CLK_HZ == 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("ctrl_frame_decoder: CLK_HZ must be nonzero and TIMEOUT_CYCLES >= 2");
    end

    localparam logic [15:0] STEER_LIM = 16'(STEER_MAX);
    localparam logic [15:0] THR_LIM   = 16'(THR_MAX);

    state_e      state_q, state_d;
    logic [15:0] sh_steer_q, sh_steer_d;
    logic [15:0] sh_thr_q, sh_thr_d;
    logic [15:0] steer_q, steer_d;
    logic [15:0] throttle_q, throttle_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        ctrl_mode_q, ctrl_mode_d;
    logic        mode_valid_q, mode_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        commit_c;
    logic        expire_c;

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid),
        .active  (state_q != S_IDLE),
        .expire_c(expire_c)
    );

    always_comb begin
        state_d      = state_q;
        sh_steer_d   = sh_steer_q;
        sh_thr_d     = sh_thr_q;
        steer_d      = steer_q;
        throttle_d   = throttle_q;
        ctrl_mode_d  = ctrl_mode_q;
        err_count_d  = err_count_q;
        cmd_valid_d  = 1'b0;
        mode_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        commit_c     = 1'b0;

        if (rx_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == HDR_A) state_d = S_HDR_B;
                end
                S_HDR_B: begin
                    if (rx_data == HDR_B) begin
                        state_d = S_CMD;
                    end else if (rx_data != HDR_A) begin
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                    end
                end
                S_CMD: begin
                    if (rx_data == CMD_CTRL) begin
                        state_d = S_ST_H;
                    end else if (rx_data == CMD_MODE) begin
                        state_d = S_MODE;
                    end else begin
                        state_d     = (rx_data == HDR_A) ? S_HDR_B : S_IDLE;
                        frame_err_d = 1'b1;
                    end
                end
                S_ST_H: begin
                    sh_steer_d[15:8] = rx_data;
                    state_d          = S_ST_L;
                end
                S_ST_L: begin
                    sh_steer_d[7:0] = rx_data;
                    state_d         = S_TH_H;
                end
                S_TH_H: begin
                    sh_thr_d[15:8] = rx_data;
                    state_d        = S_TH_L;
                end
                S_TH_L: begin
                    sh_thr_d[7:0] = rx_data;
`ifdef CTRL_FRAME_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d  = S_IDLE;
                    commit_c = 1'b1;
`endif
                end
`ifdef CTRL_FRAME_CHECKSUM_EN
                S_CSUM: begin
                    state_d = S_IDLE;
                    if (rx_data == (sh_steer_q[15:8] ^ sh_steer_q[7:0] ^ sh_thr_q[15:8] ^ sh_thr_q[7:0])) begin
                        commit_c = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
`endif
                S_MODE: begin
                    ctrl_mode_d  = rx_data[0];
                    mode_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (expire_c) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            sh_steer_d  = '0;
            sh_thr_d    = '0;
        end

        // Live outputs only ever change here, never mid-frame.
        if (commit_c) begin
            steer_d     = clamp_u16(sh_steer_d, STEER_LIM);
            throttle_d  = clamp_u16(sh_thr_d, THR_LIM);
            cmd_valid_d = 1'b1;
        end

        if (frame_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = 8'(err_count_q + 8'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sh_steer_q   <= '0;
            sh_thr_q     <= '0;
            steer_q      <= STEER_RST;
            throttle_q   <= THR_RST;
            cmd_valid_q  <= 1'b0;
            ctrl_mode_q  <= 1'b1;
            mode_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sh_steer_q   <= sh_steer_d;
            sh_thr_q     <= sh_thr_d;
            steer_q      <= steer_d;
            throttle_q   <= throttle_d;
            cmd_valid_q  <= cmd_valid_d;
            ctrl_mode_q  <= ctrl_mode_d;
            mode_valid_q <= mode_valid_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign steer      = steer_q;
    assign throttle   = throttle_q;
    assign cmd_valid  = cmd_valid_q;
    assign ctrl_mode  = ctrl_mode_q;
    assign mode_valid = mode_valid_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_ctrl_frame_decoder.sv
// Bench for ctrl_frame_decoder: a frame-buffer model checked every cycle plus
// directed frames with literal expectations. Honours CTRL_FRAME_CHECKSUM_EN.
module tb_ctrl_frame_decoder;

    localparam int unsigned TO        = 100;
    localparam int unsigned STEER_MAX = 1000;
    localparam int unsigned THR_MAX   = 1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [15:0] steer;
    logic [15:0] throttle;
    logic        cmd_valid;
    logic        ctrl_mode;
    logic        mode_valid;
    logic        frame_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    ctrl_frame_decoder #(
        .CLK_HZ(50000000),
        .TIMEOUT_CYCLES(TO),
        .STEER_MAX(STEER_MAX),
        .THR_MAX(THR_MAX)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .steer(steer), .throttle(throttle), .cmd_valid(cmd_valid),
        .ctrl_mode(ctrl_mode), .mode_valid(mode_valid),
        .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes of the frame in progress, idle time, expected outputs.
    logic [7:0] fb[$];
    int         since = 0;
    int         m_steer = 500, m_thr = 512, m_err_cnt = 0;
    logic       m_mode = 1'b1, m_cmd_v = 1'b0, m_mode_v = 1'b0, m_err = 1'b0;
`ifdef CTRL_FRAME_CHECKSUM_EN
    localparam int CTRL_LEN = 8;
`else
    localparam int CTRL_LEN = 7;
`endif

    task automatic m_flag_err();
        m_err = 1'b1;
        if (m_err_cnt < 255) m_err_cnt++;
    endtask

    task automatic m_byte(input logic [7:0] b);
        int s, t;
        if (fb.size() == 0) begin
            if (b == 8'h61) fb.push_back(b);
        end else if (fb.size() == 1) begin
            if (b == 8'h62) fb.push_back(b);
            else if (b != 8'h61) begin m_flag_err(); fb.delete(); end
        end else if (fb.size() == 2) begin
            if (b == 8'h63 || b == 8'h6D) fb.push_back(b);
            else begin
                m_flag_err();
                fb.delete();
                if (b == 8'h61) fb.push_back(b);
            end
        end else if (fb[2] == 8'h6D) begin
            m_mode   = b[0];
            m_mode_v = 1'b1;
            fb.delete();
        end else begin
            fb.push_back(b);
            if (fb.size() == CTRL_LEN) begin
                s = {fb[3], fb[4]};
                t = {fb[5], fb[6]};
                if (CTRL_LEN == 8 && fb[7] != (fb[3] ^ fb[4] ^ fb[5] ^ fb[6])) begin
                    m_flag_err();
                end else begin
                    m_steer = (s > STEER_MAX) ? STEER_MAX : s;
                    m_thr   = (t > THR_MAX) ? THR_MAX : t;
                    m_cmd_v = 1'b1;
                end
                fb.delete();
            end
        end
    endtask

    always @(posedge clk) begin
        m_cmd_v = 1'b0; m_mode_v = 1'b0; m_err = 1'b0;
        if (rst) begin
            fb.delete(); since = 0;
            m_steer = 500; m_thr = 512; m_mode = 1'b1; m_err_cnt = 0;
        end else if (rx_valid) begin
            since = 0;
            m_byte(rx_data);
        end else if (fb.size() != 0) begin
            since++;
            if (since == TO) begin
                m_flag_err();
                fb.delete();
                since = 0;
            end
        end
        #1;
        chk("steer", 32'(steer), 32'(m_steer));
        chk("throttle", 32'(throttle), 32'(m_thr));
        chk("cmd_valid", 32'(cmd_valid), 32'(m_cmd_v));
        chk("ctrl_mode", 32'(ctrl_mode), 32'(m_mode));
        chk("mode_valid", 32'(mode_valid), 32'(m_mode_v));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_err_cnt));
    end

    // Back-to-back bytes; on return the strobes of the last byte are visible.
    task automatic send(input logic [7:0] q[$]);
        foreach (q[i]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = q[i];
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_gapped(input logic [7:0] q[$], input int gap);
        foreach (q[i]) begin
            send('{q[i]});
            repeat (gap) @(negedge clk);
        end
    endtask

    function automatic logic [7:0] csum(input logic [15:0] s, input logic [15:0] t);
        return s[15:8] ^ s[7:0] ^ t[15:8] ^ t[7:0];
    endfunction

    task automatic send_ctrl(input logic [15:0] s, input logic [15:0] t);
        logic [7:0] q[$];
        q = '{8'h61, 8'h62, 8'h63, s[15:8], s[7:0], t[15:8], t[7:0]};
`ifdef CTRL_FRAME_CHECKSUM_EN
        q.push_back(csum(s, t));
`endif
        send(q);
    endtask

    initial begin
        int k;
        logic [7:0] c;
        repeat (3) @(negedge clk);
        chk("rst_steer", 32'(steer), 32'd500);
        chk("rst_throttle", 32'(throttle), 32'd512);
        chk("rst_mode", 32'(ctrl_mode), 32'd1);
        rst = 1'b0;

        c = csum(16'h01F4, 16'h0258);
        chk("csum_model", 32'(c), 32'hAF);
        send_ctrl(16'h01F4, 16'h0258);
        chk("f1_cmd_valid", 32'(cmd_valid), 32'd1);
        chk("f1_steer", 32'(steer), 32'd500);
        chk("f1_throttle", 32'(throttle), 32'd600);
        chk("f1_err_count", 32'(err_count), 32'd0);

        send_ctrl(16'h07D0, 16'h0FFF);
        chk("clamp_steer", 32'(steer), 32'd1000);
        chk("clamp_throttle", 32'(throttle), 32'd1023);
        send_ctrl(16'd1001, 16'd1023);
        chk("edge_steer", 32'(steer), 32'd1000);
        chk("edge_throttle", 32'(throttle), 32'd1023);
        send_ctrl(16'd0, 16'd1024);
        chk("zero_steer", 32'(steer), 32'd0);

        send('{8'h61, 8'h62, 8'h6D, 8'h00});
        chk("mode0_valid", 32'(mode_valid), 32'd1);
        chk("mode0", 32'(ctrl_mode), 32'd0);
        send_gapped('{8'h61, 8'h62, 8'h6D, 8'h01}, 5);
        chk("mode1", 32'(ctrl_mode), 32'd1);

        send('{8'h61, 8'h62, 8'h63, 8'h01});
        k = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            @(negedge clk);
            if (frame_err) begin k = i; break; end
        end
        chk("timeout_cycles", 32'(k), 32'(TO));
        chk("timeout_steer", 32'(steer), 32'd0);
        send_ctrl(16'd250, 16'd700);
        chk("after_to_throttle", 32'(throttle), 32'd700);

        // A byte just before expiry keeps the frame alive.
        send('{8'h61, 8'h62, 8'h63});
        repeat (TO - 2) @(negedge clk);
        send('{8'h00});
        repeat (TO - 2) @(negedge clk);
        send('{8'h10, 8'h01, 8'h00});
`ifdef CTRL_FRAME_CHECKSUM_EN
        send('{8'h11});
`endif
        chk("late_steer", 32'(steer), 32'd16);

        send('{8'h55, 8'h61, 8'h61, 8'h62, 8'h63, 8'h00, 8'h20, 8'h01, 8'h10});
`ifdef CTRL_FRAME_CHECKSUM_EN
        send('{8'h31});
`endif
        chk("resync_steer", 32'(steer), 32'd32);
        chk("resync_throttle", 32'(throttle), 32'd272);

        send('{8'h61, 8'h62, 8'h7A});
        chk("badcmd_err", 32'(frame_err), 32'd1);
        chk("badcmd_no_cmd", 32'(cmd_valid), 32'd0);
        send('{8'h61, 8'h41, 8'h61, 8'h62, 8'h61, 8'h62, 8'h6D, 8'h00});
        chk("badhdr_errs", 32'(err_count), 32'd4);

`ifdef CTRL_FRAME_CHECKSUM_EN
        send('{8'h61, 8'h62, 8'h63, 8'h00, 8'h64, 8'h01, 8'h00, 8'h00});
        chk("csum_err", 32'(frame_err), 32'd1);
        chk("csum_no_cmd", 32'(cmd_valid), 32'd0);
`endif

        for (int i = 0; i < 300; i++) send('{8'h61, 8'h62, 8'h7A});
        chk("err_saturate", 32'(err_count), 32'd255);

        send('{8'h61, 8'h62, 8'h63, 8'h01});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_steer", 32'(steer), 32'd500);
        chk("midrst_throttle", 32'(throttle), 32'd512);
        chk("midrst_mode", 32'(ctrl_mode), 32'd1);
        chk("midrst_errs", 32'(err_count), 32'd0);
        rst = 1'b0;
        send('{8'hF4, 8'h02, 8'h58, 8'hAF});
        chk("lost_frame", 32'(steer), 32'd500);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_frame_decoder.md
# ctrl_frame_decoder

Synchronous decoder for the serial remote-control link. It sits directly downstream of the UART byte receiver and upstream of the motor/servo duty logic. It assembles `a b c <steer_hi> <steer_lo> <thr_hi> <thr_lo>` control frames and `a b m <mode>` mode frames into registered, range-clamped commands with single-cycle strobes. It also adds inter-byte timeout recovery and error counting, which the edge-triggered parser it replaces lacks.

## Interface
Parameters:
- `CLK_HZ`, 50000000, system clock frequency; documentation only.
- `TIMEOUT_CYCLES`, 5000000, idle cycles allowed between bytes of one frame (100 ms at 50 MHz).
- `STEER_MAX`, 1000, upper clamp for steer; the servo stage adds 1000 µs.
- `THR_MAX`, 1023, upper clamp for throttle; 512 is stop.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a new byte; already synchronised to `clk`.
- `rx_data`  in  8  received byte.
- `steer`  out  16  last accepted steer value, 0..STEER_MAX.
- `throttle`  out  16  last accepted throttle value, 0..THR_MAX.
- `cmd_valid`  out  1  one-cycle strobe when `steer` and `throttle` update.
- `ctrl_mode`  out  1  1 = remote (UART) control, 0 = local control.
- `mode_valid`  out  1  one-cycle strobe when `ctrl_mode` is written.
- `frame_err`  out  1  one-cycle strobe on a bad header/command byte, a checksum failure or a timeout.
- `err_count`  out  8  saturating count of `frame_err` events.

## Operation
- FSM states: IDLE, HDR_B, CMD, ST_H, ST_L, TH_H, TH_L, CSUM, MODE. Every transition occurs only on a cycle with `rx_valid=1`, except timeouts.
- IDLE: byte 0x61 ('a') -> HDR_B; any other byte is silently ignored (no error).
- HDR_B:
  - 0x62 ('b') -> CMD.
  - 0x61 -> stay in HDR_B (resync).
  - Any other byte -> IDLE with `frame_err`.
- CMD:
  - 0x63 ('c') -> ST_H.
  - 0x6D ('m') -> MODE.
  - 0x61 -> HDR_B with `frame_err`.
  - Any other byte -> IDLE with `frame_err`.
- Payload path: ST_H -> ST_L -> TH_H -> TH_L capture bytes into shadow registers, big-endian. Live outputs are never modified mid-frame.
- TH_L completion commits the frame and returns to IDLE. With checksum enabled it goes to CSUM first (see Configuration).
- Commit rules:
  - `steer` = min(shadow_steer, STEER_MAX).
  - `throttle` = min(shadow_thr, THR_MAX).
  - Comparison is unsigned 16-bit.
  - `cmd_valid` pulses.
- MODE: any byte sets `ctrl_mode` <= byte[0], pulses `mode_valid`, then -> IDLE.
- Timeout:
  - A counter resets on every `rx_valid` and counts while the state is not IDLE.
  - On reaching TIMEOUT_CYCLES-1 the FSM goes to IDLE, pulses `frame_err`, and discards the shadow registers.
  - Counter width is clog2(TIMEOUT_CYCLES).
  - The counter is held at 0 in IDLE.
- Simultaneous `rx_valid` and timeout expiry: the byte wins. It is processed normally and the counter clears.
- `err_count` increments by 1 per `frame_err` and saturates at 255 without wrapping.
- Reset values:
  - State IDLE; timeout counter 0.
  - `steer` = 500, `throttle` = 512.
  - `ctrl_mode` = 1.
  - `cmd_valid`, `mode_valid`, `frame_err` = 0.
  - `err_count` = 0.
- Reset asserted mid-frame: all of the above values are restored on the next clock edge and the partial frame is lost.

## Timing
- All outputs are registered.
- `cmd_valid`, `mode_valid` and `frame_err` assert in the cycle after the edge that samples the final or offending byte, and last exactly 1 cycle.
- Updated `steer`, `throttle` and `ctrl_mode` are visible in the same cycle as their strobe.
- Back-to-back `rx_valid` on consecutive cycles is supported, sustaining one byte per clock.
- A timeout strobe fires exactly TIMEOUT_CYCLES cycles after the last accepted byte.

## Configuration
- Macro: `CTRL_FRAME_CHECKSUM_EN`.
- Defined:
  - Control frames carry an extra byte after thr_lo, handled in state CSUM.
  - The expected value is the XOR of the four payload bytes.
  - Match -> commit.
  - Mismatch -> IDLE with `frame_err` and no commit.
  - Mode frames carry no checksum.
- Undefined: state CSUM does not exist and TH_L commits directly.

## Structure
- Shared package `ctrl_link_pkg` holds:
  - FSM state enum.
  - Byte constants: HDR_A=0x61, HDR_B=0x62, CMD_CTRL=0x63, CMD_MODE=0x6D.
  - Reset constants: STEER_RST=500, THR_RST=512.
- One sub-module: `byte_timeout`, the resettable idle counter with an expiry pulse, parameterised by TIMEOUT_CYCLES.

## Test plan
- Frame 61 62 63 01 F4 02 58 (plus checksum 0xAF if enabled) -> one `cmd_valid`, `steer`=500, `throttle`=600, `err_count`=0.
- Frame with steer 0x07D0 and throttle 0x0FFF -> `steer`=1000 and `throttle`=1023 (clamped).
- Frame 61 62 6D 00 -> `mode_valid` pulse, `ctrl_mode`=0; then 61 62 6D 01 -> `ctrl_mode`=1.
- Frame 61 62 63 01 with no further bytes, TIMEOUT_CYCLES=100 -> `frame_err` 100 cycles after the last byte, outputs unchanged; a following valid frame is accepted.
- Streams 61 61 62 63 … (resync) and 61 62 7A (bad command) -> the first decodes normally; the second pulses `frame_err` with no commit. 300 bad frames -> `err_count`=255.
- With checksum enabled, a wrong checksum byte -> `frame_err`, no `cmd_valid`. Assert `rst` mid-payload -> all reset values restored on the next edge.
